// File: rtl/serial_queue_pkg.sv
// Shared types and default sizing for the serial-in word queue.
package serial_queue_pkg;

    // Deserializer states: collecting bits, or holding a finished word
    typedef enum logic {
        SHIFT = 1'b0,
        PUSH  = 1'b1
    } deser_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO storage with wrapping pointers and a separate word count.
module sync_fifo
    import serial_queue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Head word is visible combinationally so the caller can latch it on the pop edge
    assign rdata = mem[rd_ptr];

    // Storage is not reset; stale words are unreachable once count is cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Count tracks occupancy; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_queue.sv
// Serial-to-parallel deserializer feeding a word FIFO with a registered pop port.
module serial_queue
    import serial_queue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clock1M,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       dequeue_in,
    output logic                       status_out,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full_out,
    output logic                       empty_out
);

    localparam int BW = $clog2(WIDTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    deser_state_t     state;
    deser_state_t     next_state;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] head_word;
    logic             push;
    logic             pop_valid;

    assign pop_valid  = dequeue_in && (len_out != '0);
    assign full_out   = (len_out == FULL_LEVEL);
    assign empty_out  = (len_out == '0);

    // Deserializer state register
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            state <= SHIFT;
        end else begin
            state <= next_state;
        end
    end

    // Next state, push decision and busy flag; a full queue stalls in PUSH unless a pop frees a slot
    always_comb begin
        next_state = state;
        push       = 1'b0;
        status_out = 1'b0;
        case (state)
            SHIFT: begin
                if (write_in && (bit_cnt == LAST_BIT)) begin
                    next_state = PUSH;
                end
            end
            PUSH: begin
                status_out = 1'b1;
                if ((len_out != FULL_LEVEL) || pop_valid) begin
                    push       = 1'b1;
                    next_state = SHIFT;
                end
            end
            default: next_state = SHIFT;
        endcase
    end

    // Shift register and bit counter only move while collecting bits
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if ((state == SHIFT) && write_in) begin
            shift_reg <= {shift_reg[WIDTH-2:0], data_in};
            if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    // Output register captures the head word on a valid pop and pulses data_valid
    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= pop_valid;
            if (pop_valid) begin
                data_out <= head_word;
            end
        end
    end

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clock1M),
        .rst_n (reset),
        .push  (push),
        .pop   (pop_valid),
        .wdata (shift_reg),
        .rdata (head_word),
        .count (len_out)
    );

endmodule
